inst_fetch_ctrl: RTL and testbench



---
 rtl/inst_fetch_ctrl.sv | 152 +++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: drives the instruction-memory address, buffers returned
// words in a small prefetch FIFO and presents them to decode with their PC over valid/ready.
module inst_fetch_ctrl #(
   parameter int                    INST_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [INST_WIDTH-1:0] imem_data,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [INST_WIDTH-1:0] out_inst,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic                  out_fault,
   output logic                  fetch_busy
);

   // The head entry lives in its own register so out_* come straight from flops;
   // the remaining FIFO_DEPTH-1 slots form a shift-down tail behind it.
   localparam int TAIL_DEPTH = FIFO_DEPTH - 1;
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

   typedef enum logic {
      ST_FETCH,
      ST_FAULT
   } state_t;

   typedef struct packed {
      logic [INST_WIDTH-1:0] inst;
      logic [ADDR_WIDTH-1:0] pc;
      logic                  fault;
   } entry_t;

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
   entry_t                head_reg, head_next;
   logic                  head_valid_reg, head_valid_next;
   entry_t                tail_reg  [TAIL_DEPTH];
   entry_t                tail_next [TAIL_DEPTH];
   logic [CNT_W-1:0]      tail_cnt_reg, tail_cnt_next;

   logic [CNT_W-1:0]      count;
   logic                  pop;
   logic                  push;
   logic                  head_free;
   logic                  redirect_aligned;
   entry_t                push_entry;
   entry_t                fault_entry;

   assign count            = tail_cnt_reg + CNT_W'(head_valid_reg);
   assign pop              = head_valid_reg & out_ready;
   assign head_free        = ~head_valid_reg | pop;
   assign redirect_aligned = (redirect_pc[1:0] == 2'b00);
   assign push             = (state_reg == ST_FETCH) & ~redirect_valid
                             & ((count < CNT_W'(FIFO_DEPTH)) | pop);
   assign push_entry       = {imem_data, fetch_pc_reg, 1'b0};
   assign fault_entry      = {{INST_WIDTH{1'b0}}, redirect_pc, 1'b1};

   always_comb begin
      state_next      = state_reg;
      fetch_pc_next   = fetch_pc_reg;
      head_next       = head_reg;
      head_valid_next = head_valid_reg;
      tail_next       = tail_reg;
      tail_cnt_next   = tail_cnt_reg;

      if (redirect_valid) begin
         // Redirect wins over push and pop: everything buffered is dropped.
         tail_cnt_next = '0;
         if (redirect_aligned) begin
            state_next      = ST_FETCH;
            fetch_pc_next   = redirect_pc;
            head_valid_next = 1'b0;
         end else begin
            state_next      = ST_FAULT;
            head_next       = fault_entry;
            head_valid_next = 1'b1;
         end
      end else begin
         if (push) begin
            fetch_pc_next = fetch_pc_reg + ADDR_WIDTH'(4);
         end

         if (head_free) begin
            if (tail_cnt_reg != '0) begin
               head_next       = tail_reg[0];
               head_valid_next = 1'b1;
               for (int i = 0; i < TAIL_DEPTH - 1; i++) begin
                  tail_next[i] = tail_reg[i + 1];
               end
               if (push) begin
                  for (int i = 0; i < TAIL_DEPTH; i++) begin
                     if (CNT_W'(i) == tail_cnt_reg - 1'b1) begin
                        tail_next[i] = push_entry;
                     end
                  end
               end else begin
                  tail_cnt_next = tail_cnt_reg - 1'b1;
               end
            end else if (push) begin
               head_next       = push_entry;
               head_valid_next = 1'b1;
            end else begin
               // Head values are left as-is so out_inst/out_pc hold their last value.
               head_valid_next = 1'b0;
            end
         end else if (push) begin
            for (int i = 0; i < TAIL_DEPTH; i++) begin
               if (CNT_W'(i) == tail_cnt_reg) begin
                  tail_next[i] = push_entry;
               end
            end
            tail_cnt_next = tail_cnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= ST_FETCH;
         fetch_pc_reg   <= RESET_PC;
         head_reg       <= '0;
         head_valid_reg <= 1'b0;
         tail_cnt_reg   <= '0;
         for (int i = 0; i < TAIL_DEPTH; i++) begin
            tail_reg[i] <= '0;
         end
      end else begin
         state_reg      <= state_next;
         fetch_pc_reg   <= fetch_pc_next;
         head_reg       <= head_next;
         head_valid_reg <= head_valid_next;
         tail_cnt_reg   <= tail_cnt_next;
         for (int i = 0; i < TAIL_DEPTH; i++) begin
            tail_reg[i] <= tail_next[i];
         end
      end
   end

   assign imem_addr  = fetch_pc_reg;
   assign out_valid  = head_valid_reg;
   assign out_inst   = head_reg.inst;
   assign out_pc     = head_reg.pc;
   assign out_fault  = head_reg.fault;
   assign fetch_busy = (state_reg == ST_FETCH) & (count < CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed test-plan sequences with literal expectations,
// then random traffic, all compared each cycle against a queue-based reference model.
module tb_inst_fetch_ctrl;

   localparam int              IW       = 32;
   localparam int              AW       = 16;
   localparam int              DEPTH    = 2;
   localparam logic [AW-1:0]   RST_PC   = 16'h0000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_data;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          out_valid;
   logic          out_ready;
   logic [IW-1:0] out_inst;
   logic [AW-1:0] out_pc;
   logic          out_fault;
   logic          fetch_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
      return 32'hA000_0000 + 32'(a >> 2);
   endfunction

   assign imem_data = mem_word(imem_addr);

   inst_fetch_ctrl #(
      .INST_WIDTH(IW),
      .ADDR_WIDTH(AW),
      .RESET_PC  (RST_PC),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_inst      (out_inst),
      .out_pc        (out_pc),
      .out_fault     (out_fault),
      .fetch_busy    (fetch_busy)
   );

   // Reference model: a plain bounded queue of {inst, pc, fault} plus the fetch PC.
   typedef struct {
      logic [IW-1:0] inst;
      logic [AW-1:0] pc;
      logic          fault;
   } ent_t;

   ent_t          mq[$];
   logic [AW-1:0] mpc;
   bit            mfaulted;
   bit            model_on = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit   pop;
      bit   push;
      ent_t e;
      if (!rst_n) begin
         mq.delete();
         mpc      = RST_PC;
         mfaulted = 0;
         model_on = 1;
      end else if (model_on) begin
         pop = (mq.size() > 0) && out_ready;
         if (redirect_valid) begin
            mq.delete();
            if (redirect_pc[1:0] == 2'b00) begin
               mpc      = redirect_pc;
               mfaulted = 0;
            end else begin
               mfaulted = 1;
               e.inst   = '0;
               e.pc     = redirect_pc;
               e.fault  = 1'b1;
               mq.push_back(e);
            end
         end else begin
            push = !mfaulted && ((mq.size() < DEPTH) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
               e.inst  = mem_word(mpc);
               e.pc    = mpc;
               e.fault = 1'b0;
               mq.push_back(e);
               mpc = mpc + 16'd4;
            end
         end
      end
   endtask

   task automatic compare();
      if (!model_on) return;
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         chk("out_inst", out_inst, mq[0].inst);
         chk("out_pc", 32'(out_pc), 32'(mq[0].pc));
         chk("out_fault", 32'(out_fault), 32'(mq[0].fault));
      end
      chk("imem_addr", 32'(imem_addr), 32'(mpc));
      chk("fetch_busy", 32'(fetch_busy), 32'(!mfaulted && (mq.size() < DEPTH)));
   endtask

   task automatic step(input bit rn, input bit rv, input logic [AW-1:0] rpc, input bit rdy);
      rst_n          = rn;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b1;

      // Reset state
      step(0, 0, 16'h0, 1);
      step(0, 0, 16'h0, 1);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_fault", 32'(out_fault), 32'd0);
      chk("rst_inst", out_inst, 32'h0);
      chk("rst_pc", 32'(out_pc), 32'h0);
      chk("rst_addr", 32'(imem_addr), 32'(RST_PC));

      // Streaming at one word per cycle
      step(1, 0, 16'h0, 1);
      chk("first_valid", 32'(out_valid), 32'd1);
      chk("first_pc", 32'(out_pc), 32'h0);
      chk("first_inst", out_inst, 32'hA000_0000);
      step(1, 0, 16'h0, 1);
      chk("second_pc", 32'(out_pc), 32'h4);
      chk("second_inst", out_inst, 32'hA000_0001);
      step(1, 0, 16'h0, 1);
      chk("third_pc", 32'(out_pc), 32'h8);

      // Backpressure: FIFO fills, address stalls, head holds
      for (int i = 0; i < 5; i++) step(1, 0, 16'h0, 0);
      chk("bp_head_pc", 32'(out_pc), 32'h8);
      chk("bp_addr", 32'(imem_addr), 32'h10);
      chk("bp_busy", 32'(fetch_busy), 32'd0);
      step(1, 0, 16'h0, 1);
      chk("bp_resume_pc", 32'(out_pc), 32'hC);

      // Aligned redirect while full and popping
      step(1, 1, 16'h0100, 1);
      chk("redir_valid", 32'(out_valid), 32'd0);
      chk("redir_addr", 32'(imem_addr), 32'h0100);
      step(1, 0, 16'h0, 1);
      chk("redir_pc", 32'(out_pc), 32'h0100);
      chk("redir_inst", out_inst, 32'hA000_0040);
      step(1, 0, 16'h0, 1);
      chk("redir_pc2", 32'(out_pc), 32'h0104);

      // Misaligned redirect produces a single fault entry
      step(1, 1, 16'h0102, 0);
      chk("fault_valid", 32'(out_valid), 32'd1);
      chk("fault_flag", 32'(out_fault), 32'd1);
      chk("fault_pc", 32'(out_pc), 32'h0102);
      chk("fault_inst", out_inst, 32'h0);
      step(1, 0, 16'h0, 1);
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 16'h0, 1);
         chk("fault_idle", 32'(out_valid), 32'd0);
      end
      step(1, 1, 16'h0200, 1);
      step(1, 0, 16'h0, 1);
      chk("resume_pc", 32'(out_pc), 32'h0200);
      chk("resume_fault", 32'(out_fault), 32'd0);

      // Address wrap-around
      step(1, 1, 16'hFFFC, 1);
      step(1, 0, 16'h0, 1);
      chk("wrap_pc0", 32'(out_pc), 32'hFFFC);
      step(1, 0, 16'h0, 1);
      chk("wrap_pc1", 32'(out_pc), 32'h0000);
      step(1, 0, 16'h0, 1);
      chk("wrap_pc2", 32'(out_pc), 32'h0004);

      // Reset mid-stream with a fault pending
      step(1, 0, 16'h0, 0);
      step(1, 0, 16'h0, 0);
      step(1, 1, 16'h0106, 0);
      step(0, 0, 16'h0, 1);
      chk("mrst_valid", 32'(out_valid), 32'd0);
      chk("mrst_fault", 32'(out_fault), 32'd0);
      chk("mrst_addr", 32'(imem_addr), 32'(RST_PC));
      step(1, 0, 16'h0, 1);
      chk("mrst_pc", 32'(out_pc), 32'(RST_PC));
      chk("mrst_inst", out_inst, 32'hA000_0000);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         bit            rn;
         bit            rv;
         logic [AW-1:0] rpc;
         bit            rdy;
         rn  = ($urandom_range(0, 99) >= 1);
         rv  = ($urandom_range(0, 99) < 6);
         rpc = 16'($urandom_range(0, 16'hFFFF));
         if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
         rdy = ($urandom_range(0, 99) < 70);
         step(rn, rv, rpc, rdy);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
